// File: rtl/wshb_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of a single slave bus.
// The grant is registered and held for a whole bus cycle; request and response paths are combinational muxes.
module wshb_arbiter #(
  parameter int ADR_W      = 32,
  parameter int DATA_BYTES = 4
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,

  input  logic                    m0_cyc,
  input  logic                    m0_stb,
  input  logic                    m0_we,
  input  logic [ADR_W-1:0]        m0_adr,
  input  logic [8*DATA_BYTES-1:0] m0_dat_ms,
  input  logic [DATA_BYTES-1:0]   m0_sel,
  input  logic [2:0]              m0_cti,
  input  logic [1:0]              m0_bte,
  output logic                    m0_ack,
  output logic                    m0_err,
  output logic                    m0_rty,
  output logic [8*DATA_BYTES-1:0] m0_dat_sm,

  input  logic                    m1_cyc,
  input  logic                    m1_stb,
  input  logic                    m1_we,
  input  logic [ADR_W-1:0]        m1_adr,
  input  logic [8*DATA_BYTES-1:0] m1_dat_ms,
  input  logic [DATA_BYTES-1:0]   m1_sel,
  input  logic [2:0]              m1_cti,
  input  logic [1:0]              m1_bte,
  output logic                    m1_ack,
  output logic                    m1_err,
  output logic                    m1_rty,
  output logic [8*DATA_BYTES-1:0] m1_dat_sm,

  output logic                    s_cyc,
  output logic                    s_stb,
  output logic                    s_we,
  output logic [ADR_W-1:0]        s_adr,
  output logic [8*DATA_BYTES-1:0] s_dat_ms,
  output logic [DATA_BYTES-1:0]   s_sel,
  output logic [2:0]              s_cti,
  output logic [1:0]              s_bte,
  input  logic                    s_ack,
  input  logic                    s_err,
  input  logic                    s_rty,
  input  logic [8*DATA_BYTES-1:0] s_dat_sm,

  output logic [1:0]              grant
);

  // Handshake: a beat transfers on any cycle where the owner holds cyc&stb
  // and the slave returns ack/err/rty; a non-owner's stb simply stalls
  // because it never sees a response.

  // State encoding doubles as the one-hot grant, so grant is the state register.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  state_t state;
  logic   last;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (m0_cyc && (!m1_cyc || last)) begin
            state <= GNT0;
            last  <= 1'b0;
          end else if (m1_cyc) begin
            state <= GNT1;
            last  <= 1'b1;
          end
        end
        GNT0: begin
          if (!m0_cyc) begin
            if (m1_cyc) begin
              state <= GNT1;
              last  <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        GNT1: begin
          if (!m1_cyc) begin
            if (m0_cyc) begin
              state <= GNT0;
              last  <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign grant = state;

  // Read data is broadcast; each master qualifies it with its own ack.
  assign m0_dat_sm = s_dat_sm;
  assign m1_dat_sm = s_dat_sm;

  always_comb begin
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    s_we     = 1'b0;
    s_adr    = '0;
    s_dat_ms = '0;
    s_sel    = '0;
    s_cti    = '0;
    s_bte    = '0;
    m0_ack   = 1'b0;
    m0_err   = 1'b0;
    m0_rty   = 1'b0;
    m1_ack   = 1'b0;
    m1_err   = 1'b0;
    m1_rty   = 1'b0;
    case (state)
      GNT0: begin
        s_cyc    = m0_cyc;
        s_stb    = m0_stb;
        s_we     = m0_we;
        s_adr    = m0_adr;
        s_dat_ms = m0_dat_ms;
        s_sel    = m0_sel;
        s_cti    = m0_cti;
        s_bte    = m0_bte;
        m0_ack   = s_ack;
        m0_err   = s_err;
        m0_rty   = s_rty;
      end
      GNT1: begin
        s_cyc    = m1_cyc;
        s_stb    = m1_stb;
        s_we     = m1_we;
        s_adr    = m1_adr;
        s_dat_ms = m1_dat_ms;
        s_sel    = m1_sel;
        s_cti    = m1_cti;
        s_bte    = m1_bte;
        m1_ack   = s_ack;
        m1_err   = s_err;
        m1_rty   = s_rty;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wshb_arbiter.sv
// Directed bench for wshb_arbiter: reset, single master, round-robin ties,
// no-preemption burst, handover timing and mid-burst reset.
module tb_wshb_arbiter;

  localparam int ADR_W = 32;
  localparam int DB    = 4;
  localparam int DW    = 8 * DB;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;

  logic [1:0]    m_cyc, m_stb, m_we;
  logic [ADR_W-1:0] m0_adr, m1_adr;
  logic [DW-1:0] m0_dat_ms, m1_dat_ms;
  logic [DB-1:0] m0_sel, m1_sel;
  logic [2:0]    m0_cti, m1_cti;
  logic [1:0]    m0_bte, m1_bte;
  logic          m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty;
  logic [DW-1:0] m0_dat_sm, m1_dat_sm;

  logic          s_cyc, s_stb, s_we;
  logic [ADR_W-1:0] s_adr;
  logic [DW-1:0] s_dat_ms;
  logic [DB-1:0] s_sel;
  logic [2:0]    s_cti;
  logic [1:0]    s_bte;
  logic          s_ack, s_err, s_rty;
  logic [DW-1:0] s_dat_sm;
  logic [1:0]    grant;

  int tests  = 0;
  int failed = 0;

  wshb_arbiter #(.ADR_W(ADR_W), .DATA_BYTES(DB)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .m0_cyc(m_cyc[0]), .m0_stb(m_stb[0]), .m0_we(m_we[0]), .m0_adr(m0_adr),
    .m0_dat_ms(m0_dat_ms), .m0_sel(m0_sel), .m0_cti(m0_cti), .m0_bte(m0_bte),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rty(m0_rty), .m0_dat_sm(m0_dat_sm),
    .m1_cyc(m_cyc[1]), .m1_stb(m_stb[1]), .m1_we(m_we[1]), .m1_adr(m1_adr),
    .m1_dat_ms(m1_dat_ms), .m1_sel(m1_sel), .m1_cti(m1_cti), .m1_bte(m1_bte),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rty(m1_rty), .m1_dat_sm(m1_dat_sm),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_ms(s_dat_ms),
    .s_sel(s_sel), .s_cti(s_cti), .s_bte(s_bte),
    .s_ack(s_ack), .s_err(s_err), .s_rty(s_rty), .s_dat_sm(s_dat_sm),
    .grant(grant)
  );

  always #5 sys_clk = ~sys_clk;

  // Inputs change 1 ns after the edge; outputs are checked 1 ns later.
  task automatic next();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [1:0] own_gnt;
    m_cyc = 2'b00; m_stb = 2'b00; m_we = 2'b00;
    m0_adr = '0; m1_adr = '0; m0_dat_ms = 32'h0000_00A0; m1_dat_ms = 32'h0000_00B1;
    m0_sel = 4'hF; m1_sel = 4'h3; m0_cti = 3'b000; m1_cti = 3'b000;
    m0_bte = 2'b00; m1_bte = 2'b00;
    s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0; s_dat_sm = '0;

    // Reset held with m0 requesting and a stray slave ack
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m0_adr = 32'h40; s_ack = 1'b1;
    next(); next(); settle();
    chk("rst_grant", grant, 2'b00);
    chk("rst_s_cyc", s_cyc, 1'b0);
    chk("rst_m0_ack", m0_ack, 1'b0);
    sys_rst = 1'b0;
    settle();
    chk("rel_grant_same_cycle", grant, 2'b00);
    next(); settle();
    chk("rel_grant_next", grant, 2'b01);
    chk("rel_s_adr", s_adr, 32'h40);
    chk("rel_m0_ack", m0_ack, 1'b1);
    chk("rel_m1_ack", m1_ack, 1'b0);
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0; s_ack = 1'b0;
    next(); settle();
    chk("rel_idle", grant, 2'b00);

    // Single master read by m1
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m1_adr = 32'h100; settle();
    chk("rd_grant_n", grant, 2'b00);
    chk("rd_s_cyc_n", s_cyc, 1'b0);
    next(); settle();
    chk("rd_grant_n1", grant, 2'b10);
    chk("rd_s_adr_n1", s_adr, 32'h100);
    chk("rd_s_stb_n1", s_stb, 1'b1);
    chk("rd_s_sel_n1", s_sel, 4'h3);
    chk("rd_m1_ack_wait", m1_ack, 1'b0);
    next(); settle();
    chk("rd_m1_ack_wait2", m1_ack, 1'b0);
    next(); s_ack = 1'b1; s_dat_sm = 32'hDEADBEEF; settle();
    chk("rd_m1_ack", m1_ack, 1'b1);
    chk("rd_m1_dat", m1_dat_sm, 32'hDEADBEEF);
    chk("rd_m0_ack", m0_ack, 1'b0);
    next(); m_cyc[1] = 1'b0; m_stb[1] = 1'b0; s_ack = 1'b0; settle();
    chk("rd_drop_s_cyc", s_cyc, 1'b0);
    next(); settle();
    chk("rd_idle", grant, 2'b00);

    // Tie from IDLE (last=1) goes to m0, then strict alternation with
    // owners dropping cyc on their ack cycle
    m_cyc = 2'b11; m_stb = 2'b11; m0_adr = 32'h500; m1_adr = 32'h600;
    next(); settle();
    own_gnt = 2'b01;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rr_grant_%0d", i), grant, own_gnt);
      s_ack = 1'b1;
      if (own_gnt == 2'b01) begin m_cyc[0] = 1'b0; m_stb[0] = 1'b0; end
      else begin m_cyc[1] = 1'b0; m_stb[1] = 1'b0; end
      settle();
      chk($sformatf("rr_own_ack_%0d", i), own_gnt == 2'b01 ? m0_ack : m1_ack, 1'b1);
      chk($sformatf("rr_oth_ack_%0d", i), own_gnt == 2'b01 ? m1_ack : m0_ack, 1'b0);
      chk($sformatf("rr_s_cyc_drop_%0d", i), s_cyc, 1'b0);
      next(); s_ack = 1'b0; m_cyc = 2'b11; m_stb = 2'b11; settle();
      own_gnt = ~own_gnt;
      chk($sformatf("rr_handover_adr_%0d", i), s_adr, own_gnt == 2'b01 ? 32'h500 : 32'h600);
      chk($sformatf("rr_handover_cyc_%0d", i), s_cyc, 1'b1);
    end
    chk("rr_final_grant", grant, 2'b01);
    m_cyc = 2'b00; m_stb = 2'b00;
    next(); settle();
    chk("rr_idle", grant, 2'b00);

    // 8-beat m0 burst with m1 requesting throughout: no preemption
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m0_cti = 3'b010; m0_adr = 32'h200;
    next(); settle();
    chk("burst_grant0", grant, 2'b01);
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m1_adr = 32'h700;
    for (int b = 0; b < 8; b++) begin
      s_ack = 1'b1;
      m0_adr = 32'h200 + 32'(4 * b);
      m0_cti = (b == 7) ? 3'b111 : 3'b010;
      settle();
      chk($sformatf("burst_grant_b%0d", b), grant, 2'b01);
      chk($sformatf("burst_m0_ack_b%0d", b), m0_ack, 1'b1);
      chk($sformatf("burst_m1_ack_b%0d", b), m1_ack, 1'b0);
      chk($sformatf("burst_s_cti_b%0d", b), s_cti, (b == 7) ? 3'b111 : 3'b010);
      next();
    end
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0; s_ack = 1'b0; settle();
    chk("burst_end_grant", grant, 2'b01);
    chk("burst_end_m1_ack", m1_ack, 1'b0);
    next(); settle();
    chk("burst_handover", grant, 2'b10);
    chk("burst_handover_adr", s_adr, 32'h700);
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    next(); settle();
    chk("burst_idle", grant, 2'b00);

    // m1 burst interrupted by reset on beat 3
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m1_adr = 32'h300; m1_cti = 3'b010; m1_bte = 2'b01;
    next(); settle();
    chk("mrst_grant", grant, 2'b10);
    s_ack = 1'b1; next();
    m1_adr = 32'h304; next();
    m1_adr = 32'h308; settle();
    chk("mrst_beat3_ack", m1_ack, 1'b1);
    sys_rst = 1'b1; settle();
    chk("mrst_grant_async", grant, 2'b00);
    chk("mrst_s_cyc", s_cyc, 1'b0);
    chk("mrst_s_stb", s_stb, 1'b0);
    chk("mrst_m1_ack", m1_ack, 1'b0);
    next(); s_ack = 1'b0; m1_adr = 32'h300; sys_rst = 1'b0; settle();
    chk("mrst_rel_grant", grant, 2'b00);
    next(); settle();
    chk("mrst_restart_grant", grant, 2'b10);
    chk("mrst_restart_adr", s_adr, 32'h300);
    chk("mrst_restart_bte", s_bte, 2'b01);
    chk("mrst_restart_m0_ack", m0_ack, 1'b0);
    m_cyc = 2'b00; m_stb = 2'b00;
    next(); settle();
    chk("end_idle", grant, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/wshb_arbiter.md
Name: wshb_arbiter

Overview:
- Two-master, one-slave Wishbone arbiter sharing the SDRAM slave bus (wshb_if_sdram) between the video frame reader (m0) and the stream writer (m1).
- Round-robin arbitration. The grant is registered and is held for the whole bus cycle, while the owner keeps cyc high.
- The owner's request signals are muxed combinationally to the slave. Slave responses are routed only to the owner.
- Sits in Top between the video/stream masters and hw_support.wshb_ifs.

Parameters:
- ADR_W, 32, Wishbone address width.
- DATA_BYTES, 4, data bus width in bytes (data width = 8*DATA_BYTES, sel width = DATA_BYTES).

Ports:
- sys_clk  in  1  system clock, 100 MHz.
- sys_rst  in  1  reset, asynchronous, active-high.
- mN_cyc  in  1  master N cycle request (N=0,1; one port per master).
- mN_stb  in  1  master N strobe.
- mN_we  in  1  master N write enable.
- mN_adr  in  ADR_W  master N address.
- mN_dat_ms  in  8*DATA_BYTES  master N write data.
- mN_sel  in  DATA_BYTES  master N byte select.
- mN_cti  in  3  master N cycle type.
- mN_bte  in  2  master N burst type.
- mN_ack / mN_err / mN_rty  out  1 each  responses gated to master N.
- mN_dat_sm  out  8*DATA_BYTES  read data, slave dat_sm broadcast to both masters.
- s_cyc / s_stb / s_we  out  1 each  to slave.
- s_adr  out  ADR_W  to slave.
- s_dat_ms  out  8*DATA_BYTES  to slave.
- s_sel  out  DATA_BYTES  to slave.
- s_cti  out  3  to slave.
- s_bte  out  2  to slave.
- s_ack / s_err / s_rty  in  1 each  from slave.
- s_dat_sm  in  8*DATA_BYTES  from slave.
- grant  out  2  one-hot current owner (bit N = master N), 2'b00 when idle.

Behaviour:
- Clock: sys_clk. Reset: sys_rst, asynchronous, active-high.
- Registered state:
  - state ∈ {IDLE, GNT0, GNT1}.
  - last (1 bit): last master served.
- Reset values:
  - state=IDLE, last=1, so m0 wins the first tie.
  - grant=00.
  - All s_* request outputs = 0.
  - All mN_ack/err/rty = 0.
- Transitions, evaluated at posedge sys_clk:
  - IDLE:
    - m0_cyc only -> GNT0.
    - m1_cyc only -> GNT1.
    - both -> GNT(~last).
    - none -> IDLE.
  - GNTk, owner cyc=1: stay (no preemption, even if the other master requests).
  - GNTk, owner cyc=0:
    - other master cyc=1 -> GNT(other), direct, no idle bubble.
    - else -> IDLE.
  - last <= k on every entry into GNTk.
- Latency:
  - Request in cycle n with state IDLE -> grant and s_cyc/s_stb visible in cycle n+1.
  - Handover: owner drops cyc in cycle k -> other master forwarded from cycle k+1.
- Mux:
  - In GNTk: s_* = mk_* combinationally; mk_ack/err/rty = s_ack/err/rty.
  - The non-owner's ack/err/rty are forced to 0.
  - In IDLE: all s_* = 0 and all responses = 0.
- A non-owner holding cyc/stb simply waits. No response is ever returned to it, so its stb is stalled.
- Owner deasserts cyc in the same cycle as ack: s_cyc follows combinationally (goes 0 that cycle); grant moves at the next edge.
- s_dat_sm is passed to both masters unmodified. Masters must qualify it with their own ack.
- Reset mid-transfer:
  - state -> IDLE immediately (async).
  - s_cyc/s_stb drop in the same cycle.
  - No ack is delivered after reset assertion.
- No combinational path from mN_cyc to grant. grant is purely registered.

Test Plan:
- Reset: assert sys_rst with m0_cyc=1 -> grant=00, s_cyc=0, m0_ack=0. Release -> grant=01 one cycle later.
- Single master: m1 issues a read to adr=0x100, slave acks with dat_sm=0xDEADBEEF after 2 cycles -> s_adr=0x100 from cycle n+1, m1_ack=1 and m1_dat_sm=0xDEADBEEF, m0_ack stays 0.
- Tie, round-robin: both cyc=1 from IDLE after reset -> GNT0. m0 completes and drops cyc -> GNT1 next cycle. m1 drops while m0 re-requests -> GNT0. Repeat 4 times -> strict alternation 01,10,01,10.
- No preemption: m0 performs an 8-beat burst (cti=010, last beat cti=111) while m1_cyc=1 throughout -> grant stays 01 for all 8 acks; m1 receives no ack until m0_cyc=0; grant=10 exactly one cycle later.
- Handover timing: owner drops cyc in the same cycle as its last ack, other master waiting -> s_cyc=0 for at most that single cycle, other master's adr on s_adr in the following cycle.
- Mid-burst reset: assert sys_rst on beat 3 of an m1 burst -> s_cyc=0 and grant=00 in the same cycle. After release with only m1_cyc=1 -> GNT1 and the burst restarts cleanly.
